serial_pair_deser32: RTL and testbench
======================================

# serial_pair_deser32

Receive-side counterpart of the 32-bit serial compare path. The block accepts two synchronous serial bit streams (`a`, `b`), one bit pair per qualified clock, least-significant bit first. It reassembles them into two 32-bit parallel words and publishes the completed pair with an unsigned less/equal/greater verdict. It sits at the far end of a serial link whose transmitter is a pair of load/shift registers clocked on the same `clk`.

## Interface
- No parameters; word width fixed at 32.
- `clk`  input  1  system clock, all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin (or restart) reception of a new word pair.
- `en`  input  1  bit-valid strobe; `a`/`b` sampled only when high in RECV.
- `a`  input  1  serial bit of first operand.
- `b`  input  1  serial bit of second operand.
- `A`  output  32  last completed first operand.
- `B`  output  32  last completed second operand.
- `l`  output  1  completed `A` < `B` (unsigned).
- `e`  output  1  completed `A` == `B`.
- `g`  output  1  completed `A` > `B` (unsigned).
- `done`  output  1  one-cycle pulse: new `A`/`B`/flags just published.
- `busy`  output  1  high while in RECV.
- `count`  output  6  bits accepted in current word (0..31).

## Operation
- Internal shift registers `sa`, `sb` (32 b) and a 6-bit bit counter. Output registers `A`, `B`, `l`, `e`, `g` are separate and change only on completion.
- FSM states: IDLE, RECV, DONE.
  - IDLE: `busy`=0. If `start`=1, clear `sa`/`sb`/`count` and go to RECV. `en` is ignored.
  - RECV: `busy`=1. If `start`=1, clear `sa`/`sb`/`count`, stay in RECV (abort, no `done`), and discard any simultaneous bit. Otherwise, if `en`=1, shift `sa <= {a, sa[31:1]}` and `sb <= {b, sb[31:1]}`, and increment `count`.
  - RECV, completion: when `en`=1 and `count`==31, load `A <= {a, sa[31:1]}` and `B <= {b, sb[31:1]}`. In the same edge, register `l`/`e`/`g` from the compare of those exact values, reset `count` to 0, and go to DONE. The first received bit lands in bit 0.
  - DONE: `done`=1, `busy`=0. If `start`=1, clear and go to RECV. Otherwise go to IDLE.
- Exactly one of `l`/`e`/`g` is high after the first completion. All three stay 0 before it.
- `en` low in RECV: hold all state, with no timeout.
- Published outputs hold until the next completion. An aborted word never disturbs them.

## Timing
- Reset (async, immediate): state IDLE; `A`=`B`=0; `l`=`e`=`g`=0; `done`=0; `busy`=0; `count`=0; `sa`=`sb`=0.
- Deasserting `rst` mid-reception discards the partial word. The block waits in IDLE for `start`.
- `start` sampled at edge 0 → `busy`=1 from edge 0. Bits are sampled on the following edges with `en` high.
- With `en` continuously high: bits sampled at edges 1..32. `A`/`B`/flags update at edge 32. `done`=1 for exactly one cycle after edge 32. Minimum start-to-`done` is 32 edges after the `start` edge.
- All outputs are registered, with no combinational input-to-output path.
- Back-to-back words: `start` asserted during the DONE cycle re-enters RECV with no idle cycle. The next word needs 32 more `en` edges.
- `count` is visible each cycle. It reads 0 in IDLE/DONE and after a restart.

## Test plan
- Reset: assert `rst` mid-RECV after 10 bits → all outputs 0 immediately. Release, pulse `en` for 40 cycles without `start` → no `done`, `count` stays 0.
- Basic word: `start`, then 32 `en` cycles shifting `A`=0x0000_0005, `B`=0x0000_0003 LSB first → after edge 32, `A`=0x5, `B`=0x3, `g`=1, `l`=`e`=0, `done` high one cycle.
- Equal and MSB cases: send 0xFFFF_FFFF/0xFFFF_FFFF → `e`=1. Send 0x8000_0000/0x7FFF_FFFF → `g`=1 (unsigned).
- Gapped strobe: send 0x1234_5678/0x8765_4321 with `en` low on every third cycle → `l`=1, words exact. `done` comes only after the 32nd accepted bit.
- Abort: after 20 bits of 0xAAAA_AAAA, assert `start` together with `en` high → `count`=0 and no `done`; previous `A`/`B`/flags unchanged. A following full word of 0x1/0x2 gives `l`=1.
- Back-to-back: `start` held during the DONE cycle, then a second pair 0x0/0x0 → second `done` exactly 33 cycles after the first, with `e`=1.

Source files
------------

// File: rtl/serial_pair_deser32.sv
// Deserialises two LSB-first serial streams into 32-bit words and publishes
// each completed pair together with an unsigned less/equal/greater verdict.
module serial_pair_deser32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        en,
    input  logic        a,
    input  logic        b,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        l,
    output logic        e,
    output logic        g,
    output logic        done,
    output logic        busy,
    output logic [5:0]  count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sa_q, sa_d;
    logic [31:0] sb_q, sb_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] a_out_q, a_out_d;
    logic [31:0] b_out_q, b_out_d;
    logic        l_q, l_d;
    logic        e_q, e_d;
    logic        g_q, g_d;
    logic        busy_d;
    logic        done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RECV;
            ST_RECV: if (!start && en && (count_q == 6'd31)) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RECV : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_q == ST_RECV);
        done_d = (state_q == ST_DONE);
    end

    // Start wins over a simultaneous bit: a restart discards the partial word.
    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        count_d = count_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
        if (start) begin
            sa_d    = '0;
            sb_d    = '0;
            count_d = '0;
        end else if ((state_q == ST_RECV) && en) begin
            sa_d    = {a, sa_q[31:1]};
            sb_d    = {b, sb_q[31:1]};
            count_d = count_q + 6'd1;
            if (count_q == 6'd31) begin
                count_d = '0;
                a_out_d = sa_d;
                b_out_d = sb_d;
                l_d     = (sa_d < sb_d);
                e_d     = (sa_d == sb_d);
                g_d     = (sa_d > sb_d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q    <= '0;
            sb_q    <= '0;
            count_q <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            count_q <= count_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
        end
    end

    assign A     = a_out_q;
    assign B     = b_out_q;
    assign l     = l_q;
    assign e     = e_q;
    assign g     = g_q;
    assign busy  = busy_d;
    assign done  = done_d;
    assign count = count_q;

endmodule

// File: tb/tb_serial_pair_deser32.sv
// Directed bench for serial_pair_deser32: a word-level model predicts every
// output each cycle, and literal checks pin the key results.
module tb_serial_pair_deser32;

    logic        clk = 1'b0;
    logic        rst, start, en, a, b;
    logic [31:0] A, B;
    logic        l, e, g, done, busy;
    logic [5:0]  count;

    serial_pair_deser32 dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .a(a), .b(b),
        .A(A), .B(B), .l(l), .e(e), .g(g),
        .done(done), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: receiving flag, accepted-bit count, words built by bit position.
    bit          m_recv, m_done;
    int          m_cnt;
    logic [31:0] m_wa, m_wb, m_A, m_B;
    bit          m_l, m_e, m_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_recv = 0; m_done = 0; m_cnt = 0;
        m_wa = '0; m_wb = '0; m_A = '0; m_B = '0;
        m_l = 0; m_e = 0; m_g = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (start) begin
            m_recv = 1;
            m_cnt  = 0;
            m_wa   = '0;
            m_wb   = '0;
        end else if (m_recv && en) begin
            m_wa  = m_wa | (32'(a) << m_cnt);
            m_wb  = m_wb | (32'(b) << m_cnt);
            m_cnt = m_cnt + 1;
            if (m_cnt == 32) begin
                m_A = m_wa; m_B = m_wb;
                m_l = (m_wa < m_wb); m_e = (m_wa == m_wb); m_g = (m_wa > m_wb);
                m_cnt  = 0;
                m_recv = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic drive(input logic s, input logic en_i, input logic a_i, input logic b_i);
        start = s; en = en_i; a = a_i; b = b_i;
        @(posedge clk);
        cyc++;
        if (!rst) model_step();
        #1;
    endtask

    task automatic send_bits(input logic [31:0] wa, input logic [31:0] wb, input bit gap);
        int k = 0;
        for (int i = 0; i < 32; i++) begin
            if (gap && (k % 3 == 2)) begin
                drive(1'b0, 1'b0, ~wa[i], ~wb[i]);
                k++;
            end
            if (i == 31) check("cnt_before_last", {26'd0, count}, 32'd31);
            drive(1'b0, 1'b1, wa[i], wb[i]);
            k++;
        end
    endtask

    always @(negedge clk) begin
        check("A", A, m_A);
        check("B", B, m_B);
        check("l", {31'd0, l}, {31'd0, m_l});
        check("e", {31'd0, e}, {31'd0, m_e});
        check("g", {31'd0, g}, {31'd0, m_g});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("busy", {31'd0, busy}, {31'd0, m_recv});
        check("count", {26'd0, count}, 32'(m_cnt));
    end

    task automatic check_flags(input string name, input bit el, input bit ee, input bit eg);
        check({name, "_l"}, {31'd0, l}, {31'd0, el});
        check({name, "_e"}, {31'd0, e}, {31'd0, ee});
        check({name, "_g"}, {31'd0, g}, {31'd0, eg});
    endtask

    initial begin
        int t1, t2;
        rst = 1'b1; start = 0; en = 0; a = 0; b = 0;
        model_reset();
        repeat (3) drive(0, 0, 0, 0);
        rst = 1'b0;
        check("rst_A", A, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_flags("rst", 0, 0, 0);

        // Basic word 5 vs 3
        drive(1, 0, 0, 0);
        check("start_busy", {31'd0, busy}, 32'd1);
        send_bits(32'h5, 32'h3, 0);
        check("basic_A", A, 32'h5);
        check("basic_B", B, 32'h3);
        check("basic_done", {31'd0, done}, 32'd1);
        check("model_A", m_A, 32'h5);
        check_flags("basic", 0, 0, 1);
        drive(0, 0, 0, 0);
        check("basic_done_drop", {31'd0, done}, 32'd0);

        // Equal all-ones
        drive(1, 0, 0, 0);
        send_bits(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("eq_A", A, 32'hFFFF_FFFF);
        check_flags("eq", 0, 1, 0);
        drive(0, 0, 0, 0);

        // MSB unsigned compare
        drive(1, 0, 0, 0);
        send_bits(32'h8000_0000, 32'h7FFF_FFFF, 0);
        check("msb_A", A, 32'h8000_0000);
        check("msb_B", B, 32'h7FFF_FFFF);
        check_flags("msb", 0, 0, 1);
        drive(0, 0, 0, 0);

        // Gapped strobe
        drive(1, 0, 0, 0);
        send_bits(32'h1234_5678, 32'h8765_4321, 1);
        check("gap_A", A, 32'h1234_5678);
        check("gap_B", B, 32'h8765_4321);
        check("gap_done", {31'd0, done}, 32'd1);
        check_flags("gap", 1, 0, 0);
        drive(0, 0, 0, 0);

        // Reset in the middle of a word
        drive(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 1'b1, 1'b0);
        check("mid_count", {26'd0, count}, 32'd10);
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_A", A, 32'h0);
        check("arst_B", B, 32'h0);
        check("arst_count", {26'd0, count}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check_flags("arst", 0, 0, 0);
        drive(0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) drive(0, 1, i[0], ~i[0]);
        check("noStart_count", {26'd0, count}, 32'd0);
        check("noStart_done", {31'd0, done}, 32'd0);
        check("noStart_busy", {31'd0, busy}, 32'd0);

        // Publish 5/3, then abort a partial word
        drive(1, 0, 0, 0);
        send_bits(32'h5, 32'h3, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, i[0], ~i[0]);
        check("pre_abort_count", {26'd0, count}, 32'd20);
        drive(1, 1, 1, 1);
        check("abort_count", {26'd0, count}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        check("abort_A", A, 32'h5);
        check("abort_B", B, 32'h3);
        check_flags("abort", 0, 0, 1);
        send_bits(32'h1, 32'h2, 0);
        check("after_abort_A", A, 32'h1);
        check("after_abort_B", B, 32'h2);
        check_flags("after_abort", 1, 0, 0);

        // Back-to-back: start during the DONE cycle
        t1 = cyc;
        drive(1, 0, 0, 0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        send_bits(32'h0, 32'h0, 0);
        t2 = cyc;
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_spacing", 32'(t2 - t1), 32'd33);
        check("b2b_A", A, 32'h0);
        check_flags("b2b", 0, 1, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
